// File: rtl/stdp_pkg.sv
// Shared types and defaults for the STDP update scheduler.
// Latency: none (declarations only).
// Backpressure: none.
package stdp_pkg;

    localparam int WEIGHT_W_DEF = 8;
    localparam int W_INIT_DEF   = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_READ,
        ST_UPDATE,
        ST_WRITE
    } state_t;

    typedef enum logic [1:0] {
        UPD_NONE,
        UPD_INCR,
        UPD_DECR,
        UPD_SIM
    } upd_kind_t;

    // Id-select rule: pre-only strengthens, post-only weakens, both together leave the weight alone
    function automatic upd_kind_t classify(input logic pre, input logic post);
        upd_kind_t k;
        k = UPD_NONE;
        if (pre && !post)      k = UPD_INCR;
        else if (!pre && post) k = UPD_DECR;
        else if (pre && post)  k = UPD_SIM;
        return k;
    endfunction

endpackage

// File: rtl/stdp_rr_arb.sv
// Round-robin pick of the first pending synapse at or after rr_ptr.
// Latency: combinational.
// Backpressure: none; the caller decides when to consume the grant.
module stdp_rr_arb #(
    parameter int N_SYN  = 4,
    parameter int ADDR_W = 2
) (
    input  logic [N_SYN-1:0]  req,
    input  logic [ADDR_W-1:0] rr_ptr,
    output logic [ADDR_W-1:0] gnt_idx,
    output logic              any_req
);

    // Scan N_SYN slots starting at rr_ptr, wrapping at N_SYN; first hit wins
    always_comb begin
        int idx;
        idx     = 0;
        gnt_idx = '0;
        any_req = 1'b0;
        for (int k = 0; k < N_SYN; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_SYN) idx = idx - N_SYN;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                gnt_idx = ADDR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/stdp_update_sched.sv
// STDP weight-update scheduler: latches spikes, RR-serves synapses, saturating RMW on a weight file.
// Latency: 5 cycles from a visible pend bit to upd_valid; one update per 5 cycles.
// Backpressure: none; events are OR-latched so bursts merge. STDP_SIM_COUNT_EN adds the sim_count output.
module stdp_update_sched
    import stdp_pkg::*;
#(
    parameter int N_SYN    = 4,
    parameter int ADDR_W   = 2,
    parameter int WEIGHT_W = WEIGHT_W_DEF,
    parameter int W_INIT   = W_INIT_DEF,
    parameter int STEP     = 1,
    parameter int W_MAX    = 255,
    parameter int W_MIN    = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                learn_en,
    input  logic [N_SYN-1:0]    pre_spike,
    input  logic                post_spike,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [WEIGHT_W-1:0] rd_data,
    output logic                busy,
    output logic                upd_valid,
    output logic [ADDR_W-1:0]   upd_addr,
    output logic [WEIGHT_W-1:0] upd_weight,
    output logic                upd_incr,
    output logic                upd_decr,
`ifdef STDP_SIM_COUNT_EN
    output logic                upd_sim,
    output logic [15:0]         sim_count
`else
    output logic                upd_sim
`endif
);

    // Saturation arithmetic runs one bit wider so incr/decr never wrap before clamping
    localparam logic [WEIGHT_W:0]   STEP_X = (WEIGHT_W+1)'(STEP);
    localparam logic [WEIGHT_W:0]   MAX_X  = (WEIGHT_W+1)'(W_MAX);
    localparam logic [WEIGHT_W:0]   MIN_X  = (WEIGHT_W+1)'(W_MIN);
    localparam logic [WEIGHT_W-1:0] INIT_W = WEIGHT_W'(W_INIT);

    state_t                state_q, state_d;
    logic [N_SYN-1:0]      pend_pre_q, pend_pre_d;
    logic [N_SYN-1:0]      pend_post_q, pend_post_d;
    logic [ADDR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]     gnt_idx_q, gnt_idx_d;
    logic                  snap_pre_q, snap_pre_d;
    logic                  snap_post_q, snap_post_d;
    logic [WEIGHT_W-1:0]   w_q, w_d;
    logic [WEIGHT_W-1:0]   w_n_q, w_n_d;
    upd_kind_t             kind_q, kind_d;
    logic [WEIGHT_W-1:0]   weight_q [N_SYN];
    logic [WEIGHT_W-1:0]   weight_d [N_SYN];
    logic                  upd_valid_q, upd_valid_d;
    logic [ADDR_W-1:0]     upd_addr_q, upd_addr_d;
    logic [WEIGHT_W-1:0]   upd_weight_q, upd_weight_d;
    logic                  upd_incr_q, upd_incr_d;
    logic                  upd_decr_q, upd_decr_d;
    logic                  upd_sim_q, upd_sim_d;
    logic [WEIGHT_W:0]     inc_x, dec_x;

    logic [ADDR_W-1:0]     arb_idx;
    logic                  arb_any;

    stdp_rr_arb #(
        .N_SYN  (N_SYN),
        .ADDR_W (ADDR_W)
    ) u_arb (
        .req     (pend_pre_q | pend_post_q),
        .rr_ptr  (rr_ptr_q),
        .gnt_idx (arb_idx),
        .any_req (arb_any)
    );

    // Next-state logic: fixed five-state walk once anything is pending
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (arb_any) state_d = ST_GRANT;
            ST_GRANT:  state_d = ST_READ;
            ST_READ:   state_d = ST_UPDATE;
            ST_UPDATE: state_d = ST_WRITE;
            ST_WRITE:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Pending latch and grant capture; a same-cycle event is OR'd in after the clear so it survives
    always_comb begin
        pend_pre_d  = pend_pre_q;
        pend_post_d = pend_post_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_idx_d   = gnt_idx_q;
        snap_pre_d  = snap_pre_q;
        snap_post_d = snap_post_q;
        if (state_q == ST_GRANT) begin
            gnt_idx_d            = arb_idx;
            snap_pre_d           = pend_pre_q[arb_idx];
            snap_post_d          = pend_post_q[arb_idx];
            pend_pre_d[arb_idx]  = 1'b0;
            pend_post_d[arb_idx] = 1'b0;
            rr_ptr_d             = (int'(arb_idx) == N_SYN - 1) ? '0 : arb_idx + 1'b1;
        end
        if (learn_en) begin
            pend_pre_d  = pend_pre_d | pre_spike;
            pend_post_d = pend_post_d | {N_SYN{post_spike}};
        end
    end

    // Read, classify + saturate, then write back and raise the one-cycle strobe
    always_comb begin
        w_d          = w_q;
        w_n_d        = w_n_q;
        kind_d       = kind_q;
        weight_d     = weight_q;
        upd_valid_d  = 1'b0;
        upd_addr_d   = upd_addr_q;
        upd_weight_d = upd_weight_q;
        upd_incr_d   = 1'b0;
        upd_decr_d   = 1'b0;
        upd_sim_d    = 1'b0;
        inc_x        = {1'b0, w_q} + STEP_X;
        dec_x        = {1'b0, w_q} - STEP_X;
        case (state_q)
            ST_READ: w_d = weight_q[gnt_idx_q];
            ST_UPDATE: begin
                kind_d = classify(snap_pre_q, snap_post_q);
                case (kind_d)
                    UPD_INCR: w_n_d = (inc_x > MAX_X) ? MAX_X[WEIGHT_W-1:0] : inc_x[WEIGHT_W-1:0];
                    UPD_DECR: w_n_d = ({1'b0, w_q} < MIN_X + STEP_X) ? MIN_X[WEIGHT_W-1:0]
                                                                    : dec_x[WEIGHT_W-1:0];
                    default:  w_n_d = w_q;
                endcase
            end
            ST_WRITE: begin
                weight_d[gnt_idx_q] = w_n_q;
                upd_valid_d         = 1'b1;
                upd_addr_d          = gnt_idx_q;
                upd_weight_d        = w_n_q;
                upd_incr_d          = (kind_q == UPD_INCR);
                upd_decr_d          = (kind_q == UPD_DECR);
                upd_sim_d           = (kind_q == UPD_SIM);
            end
            default: ;
        endcase
    end

    // State and datapath registers; reset drops any update in flight without a strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pend_pre_q   <= '0;
            pend_post_q  <= '0;
            rr_ptr_q     <= '0;
            gnt_idx_q    <= '0;
            snap_pre_q   <= 1'b0;
            snap_post_q  <= 1'b0;
            w_q          <= '0;
            w_n_q        <= '0;
            kind_q       <= UPD_NONE;
            for (int i = 0; i < N_SYN; i++) weight_q[i] <= INIT_W;
            upd_valid_q  <= 1'b0;
            upd_addr_q   <= '0;
            upd_weight_q <= '0;
            upd_incr_q   <= 1'b0;
            upd_decr_q   <= 1'b0;
            upd_sim_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_pre_q   <= pend_pre_d;
            pend_post_q  <= pend_post_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_idx_q    <= gnt_idx_d;
            snap_pre_q   <= snap_pre_d;
            snap_post_q  <= snap_post_d;
            w_q          <= w_d;
            w_n_q        <= w_n_d;
            kind_q       <= kind_d;
            weight_q     <= weight_d;
            upd_valid_q  <= upd_valid_d;
            upd_addr_q   <= upd_addr_d;
            upd_weight_q <= upd_weight_d;
            upd_incr_q   <= upd_incr_d;
            upd_decr_q   <= upd_decr_d;
            upd_sim_q    <= upd_sim_d;
        end
    end

`ifdef STDP_SIM_COUNT_EN
    logic [15:0] sim_count_q, sim_count_d;

    // Count committed sim updates, sticking at all-ones; moves together with the upd_sim strobe
    always_comb begin
        sim_count_d = sim_count_q;
        if (state_q == ST_WRITE && kind_q == UPD_SIM && sim_count_q != 16'hFFFF)
            sim_count_d = sim_count_q + 16'd1;
    end

    // Sim counter register
    always_ff @(posedge clk) begin
        if (rst) sim_count_q <= '0;
        else     sim_count_q <= sim_count_d;
    end

    assign sim_count = sim_count_q;
`endif

    assign rd_data    = weight_q[rd_addr];
    assign busy       = (state_q != ST_IDLE);
    assign upd_valid  = upd_valid_q;
    assign upd_addr   = upd_addr_q;
    assign upd_weight = upd_weight_q;
    assign upd_incr   = upd_incr_q;
    assign upd_decr   = upd_decr_q;
    assign upd_sim    = upd_sim_q;

endmodule

// File: tb/tb_stdp_update_sched.sv
// Self-checking bench for stdp_update_sched: directed table, corner sequences, random bursts.
// Latency: checks the 5-cycle pend-to-strobe delay and 5-cycle spacing of each strobe.
// Backpressure: none; the bench waits a bounded number of cycles per burst.
module tb_stdp_update_sched;

    localparam int N  = 4;
    localparam int WI = 128;
    localparam int WX = 255;
    localparam int WN = 0;
    localparam int ST = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       learn_en = 1'b0;
    logic [3:0] pre_spike = '0;
    logic       post_spike = 1'b0;
    logic [1:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       busy, upd_valid, upd_incr, upd_decr, upd_sim;
    logic [1:0] upd_addr;
    logic [7:0] upd_weight;
`ifdef STDP_SIM_COUNT_EN
    logic [15:0] sim_count;
`endif

    stdp_update_sched dut (
        .clk        (clk),
        .rst        (rst),
        .learn_en   (learn_en),
        .pre_spike  (pre_spike),
        .post_spike (post_spike),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .upd_valid  (upd_valid),
        .upd_addr   (upd_addr),
        .upd_weight (upd_weight),
        .upd_incr   (upd_incr),
        .upd_decr   (upd_decr),
`ifdef STDP_SIM_COUNT_EN
        .upd_sim    (upd_sim),
        .sim_count  (sim_count)
`else
        .upd_sim    (upd_sim)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] weight;
        logic [2:0] kind;   // {incr, decr, sim}
        int         cyc;
    } strobe_t;

    typedef struct {
        logic [3:0]  pre;
        logic        post;
        logic        learn;
        int          n_exp;
        int          first_addr;
        logic [31:0] w;     // {w3, w2, w1, w0}
    } vec_t;

    strobe_t dut_q[$];
    strobe_t exp_q[$];
    int      cyc = 0;
    int      n_cmp = 0;
    int      n_bad = 0;

    // Reference state: weights, RR pointer, sim tally
    int mw[N];
    int mptr;
    int msim;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (upd_valid === 1'b1)
            dut_q.push_back('{addr: upd_addr, weight: upd_weight,
                              kind: {upd_incr, upd_decr, upd_sim}, cyc: cyc});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_strobe(input int i, input strobe_t a, input strobe_t e);
        n_cmp++;
        if (a.addr !== e.addr || a.weight !== e.weight || a.kind !== e.kind || a.cyc != e.cyc) begin
            n_bad++;
            $display("FAIL strobe[%0d]: got addr=%0d w=%0d kind=%b cyc=%0d expected addr=%0d w=%0d kind=%b cyc=%0d",
                     i, a.addr, a.weight, a.kind, a.cyc, e.addr, e.weight, e.kind, e.cyc);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) mw[i] = WI;
        mptr = 0;
        msim = 0;
    endfunction

    // All pend bits of one burst become visible together, so service is simply RR order from mptr
    function automatic void model_burst(input logic [3:0] pre, input logic post, input logic learn, input int n0);
        int cnt = 0;
        int last = 0;
        if (!learn) return;
        for (int k = 0; k < N; k++) begin
            int idx = (mptr + k) % N;
            strobe_t s;
            if (pre[idx] || post) begin
                s.addr = 2'(idx);
                if (pre[idx] && !post) begin
                    mw[idx] = (mw[idx] + ST > WX) ? WX : mw[idx] + ST;
                    s.kind  = 3'b100;
                end else if (!pre[idx] && post) begin
                    mw[idx] = (mw[idx] - ST < WN) ? WN : mw[idx] - ST;
                    s.kind  = 3'b010;
                end else begin
                    s.kind  = 3'b001;
                    msim++;
                end
                s.weight = 8'(mw[idx]);
                s.cyc    = n0 + 5 + 5 * cnt;
                exp_q.push_back(s);
                cnt++;
                last = idx;
            end
        end
        if (cnt > 0) mptr = (last + 1) % N;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; learn_en = 1'b0; pre_spike = '0; post_spike = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        dut_q.delete();
    endtask

    task automatic check_model_weights();
        for (int a = 0; a < N; a++) begin
            rd_addr = 2'(a);
            #1;
            check($sformatf("rd_data[%0d]", a), 32'(rd_data), 32'(mw[a]));
        end
    endtask

    // One-cycle burst, then bounded wait with learn_en low and random spike noise
    task automatic run_burst(input logic [3:0] pre, input logic post, input logic learn, output int n_got);
        int n0;
        int waitn;
        dut_q.delete();
        exp_q.delete();
        @(negedge clk);
        pre_spike = pre; post_spike = post; learn_en = learn;
        n0 = cyc + 1;
        model_burst(pre, post, learn, n0);
        waitn = exp_q.size() * 5 + 8;
        for (int i = 0; i <= waitn; i++) begin
            @(negedge clk);
            learn_en   = 1'b0;
            pre_spike  = 4'($urandom_range(0, 15));
            post_spike = 1'($urandom_range(0, 1));
        end
        pre_spike = '0; post_spike = 1'b0;
        check("strobe_count", 32'(dut_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < dut_q.size()) check_strobe(i, dut_q[i], exp_q[i]);
`ifdef STDP_SIM_COUNT_EN
        check("sim_count", 32'(sim_count), 32'(msim));
`endif
        n_got = dut_q.size();
    endtask

    initial begin
        vec_t vt[5];
        int   n_got;

        vt[0] = '{pre: 4'b0001, post: 1'b0, learn: 1'b1, n_exp: 1, first_addr: 0, w: {8'd128, 8'd128, 8'd128, 8'd129}};
        vt[1] = '{pre: 4'b0000, post: 1'b1, learn: 1'b1, n_exp: 4, first_addr: 1, w: {8'd127, 8'd127, 8'd127, 8'd128}};
        vt[2] = '{pre: 4'b0100, post: 1'b1, learn: 1'b1, n_exp: 4, first_addr: 1, w: {8'd126, 8'd127, 8'd126, 8'd127}};
        vt[3] = '{pre: 4'b1111, post: 1'b1, learn: 1'b0, n_exp: 0, first_addr: 0, w: {8'd126, 8'd127, 8'd126, 8'd127}};
        vt[4] = '{pre: 4'b0010, post: 1'b0, learn: 1'b1, n_exp: 1, first_addr: 1, w: {8'd126, 8'd127, 8'd127, 8'd127}};

        // Reset values
        repeat (2) @(negedge clk);
        do_reset();
        check("rst_busy", 32'(busy), 0);
        check("rst_upd_valid", 32'(upd_valid), 0);
        check("rst_upd_addr", 32'(upd_addr), 0);
        check("rst_upd_weight", 32'(upd_weight), 0);
        check("rst_upd_kind", 32'({upd_incr, upd_decr, upd_sim}), 0);
        check_model_weights();

        // Directed table: hand-derived strobe counts, first address and final weights
        for (int v = 0; v < 5; v++) begin
            run_burst(vt[v].pre, vt[v].post, vt[v].learn, n_got);
            check($sformatf("vec%0d_count", v), 32'(n_got), 32'(vt[v].n_exp));
            if (vt[v].n_exp > 0 && dut_q.size() > 0)
                check($sformatf("vec%0d_first_addr", v), 32'(dut_q[0].addr), 32'(vt[v].first_addr));
            for (int a = 0; a < N; a++) begin
                rd_addr = 2'(a);
                #1;
                check($sformatf("vec%0d_w%0d", v, a), 32'(rd_data), 32'(vt[v].w[a*8 +: 8]));
            end
        end

        // Random bursts against the reference model
        for (int r = 0; r < 40; r++) begin
            run_burst(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 4) != 0), n_got);
            check_model_weights();
        end

        // Reset while the FSM sits in UPDATE: no strobe, nothing left pending
        @(negedge clk);
        pre_spike = 4'b1111; post_spike = 1'b0; learn_en = 1'b1;
        @(negedge clk);
        pre_spike = '0; learn_en = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_busy_before", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy_after", 32'(busy), 0);
        check("midrst_upd_valid", 32'(upd_valid), 0);
        rst = 1'b0;
        model_reset();
        dut_q.delete();
        repeat (30) @(negedge clk);
        check("midrst_no_strobes", 32'(dut_q.size()), 0);
        check_model_weights();

        // Saturate high on synapse 3
        do_reset();
        for (int i = 0; i < 130; i++) run_burst(4'b1000, 1'b0, 1'b1, n_got);
        check("sat_hi_strobe_seen", 32'(n_got), 1);
        if (dut_q.size() > 0) check("sat_hi_strobe_w", 32'(dut_q[0].weight), 255);
        rd_addr = 2'd3;
        #1;
        check("sat_hi_w3", 32'(rd_data), 255);

        // Saturate low on synapse 3; the other synapses see sim and hold at reset value
        do_reset();
        for (int i = 0; i < 130; i++) run_burst(4'b0111, 1'b1, 1'b1, n_got);
        check("sat_lo_strobes", 32'(n_got), 4);
        rd_addr = 2'd3;
        #1;
        check("sat_lo_w3", 32'(rd_data), 0);
        rd_addr = 2'd0;
        #1;
        check("sat_lo_w0", 32'(rd_data), 128);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
